// File: rtl/magma_req_arbiter.sv
// Round-robin front end that shares one magma_cipher core among NUM_REQ clients.
// Build with MAGMA_ARB_TIMEOUT_EN to add a WAIT watchdog that returns rsp_err.
module magma_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int BLOCK_SIZE     = 64,
  parameter int KEY_SIZE       = 256,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*BLOCK_SIZE-1:0] req_data,
  input  logic [NUM_REQ*KEY_SIZE-1:0]   req_key,
  input  logic [NUM_REQ-1:0]            req_encrypt,
  output logic [NUM_REQ-1:0]            rsp_valid,
  input  logic [NUM_REQ-1:0]            rsp_ready,
  output logic [BLOCK_SIZE-1:0]         rsp_data,
  output logic                          rsp_err,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          core_start,
  output logic                          core_encrypt,
  output logic [BLOCK_SIZE-1:0]         core_data_in,
  output logic [KEY_SIZE-1:0]           core_key,
  input  logic [BLOCK_SIZE-1:0]         core_data_out,
  input  logic                          core_busy,
  input  logic                          core_ready
);

  localparam int IW = $clog2(NUM_REQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]            state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         gid;
  logic [BLOCK_SIZE-1:0] lat_data;
  logic [KEY_SIZE-1:0]   lat_key;
  logic                  lat_enc;
  logic [BLOCK_SIZE-1:0] rsp_q;
  logic                  any;
  logic [IW-1:0]         pick;
  logic                  active;
  logic                  expire;

  // first pending requester at or above ptr, wrapping around
  always_comb begin
    int idx;
    idx  = 0;
    any  = 1'b0;
    pick = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!any && req_valid[idx]) begin
        any  = 1'b1;
        pick = IW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && any)
      req_ready[pick] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (state == S_RESP)
      rsp_valid[gid] = 1'b1;
  end

  assign active       = (state == S_START) || (state == S_WAIT);
  assign core_start   = (state == S_START) && !core_busy;
  assign core_data_in = active ? lat_data : '0;
  assign core_key     = active ? lat_key : '0;
  assign core_encrypt = active && lat_enc;
  assign grant_id     = gid;
  assign rsp_data     = rsp_q;

`ifdef MAGMA_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tcnt;
  logic          err_q;

  assign expire = (state == S_WAIT) && !core_ready &&
                  (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_START)
        tcnt <= '0;
      else if (state == S_WAIT)
        tcnt <= tcnt + 1'b1;
      if (expire)
        err_q <= 1'b1;
      else if (state == S_RESP && rsp_ready[gid])
        err_q <= 1'b0;
    end
  end
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign expire         = 1'b0;
  assign rsp_err        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      gid      <= '0;
      lat_data <= '0;
      lat_key  <= '0;
      lat_enc  <= 1'b0;
      rsp_q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (any) begin
            gid      <= pick;
            lat_data <= req_data[pick*BLOCK_SIZE +: BLOCK_SIZE];
            lat_key  <= req_key[pick*KEY_SIZE +: KEY_SIZE];
            lat_enc  <= req_encrypt[pick];
            state    <= S_START;
          end
        end
        S_START: begin
          if (!core_busy)
            state <= S_WAIT;
        end
        S_WAIT: begin
          if (core_ready) begin
            rsp_q <= core_data_out;
            state <= S_RESP;
          end else if (expire) begin
            rsp_q <= '0;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready[gid]) begin
            state <= S_IDLE;
            ptr   <= (gid == IW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_magma_req_arbiter.sv
// Bench for magma_req_arbiter: core stub, cycle model, directed and random traffic.
// Default build (no watchdog); rsp_err is expected to stay 0.
module tb_magma_req_arbiter;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req_valid;
  logic [3:0]    req_ready;
  logic [255:0]  req_data;
  logic [1023:0] req_key;
  logic [3:0]    req_encrypt;
  logic [3:0]    rsp_valid;
  logic [3:0]    rsp_ready;
  logic [63:0]   rsp_data;
  logic          rsp_err;
  logic [1:0]    grant_id;
  logic          core_start;
  logic          core_encrypt;
  logic [63:0]   core_data_in;
  logic [255:0]  core_key;
  logic [63:0]   core_data_out;
  logic          core_busy;
  logic          core_ready;

  magma_req_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_key(req_key),
    .req_encrypt(req_encrypt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .grant_id(grant_id),
    .core_start(core_start), .core_encrypt(core_encrypt),
    .core_data_in(core_data_in), .core_key(core_key),
    .core_data_out(core_data_out),
    .core_busy(core_busy), .core_ready(core_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [255:0] act,
                     input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // core stub: ready 34 cycles after the start cycle, result ~data or data^key
  logic        force_busy = 1'b0;
  logic        spur = 1'b0;
  logic        stub_act;
  logic        stub_rdy;
  int          stub_k;
  logic [63:0] stub_res;

  always @(posedge clk) begin
    if (rst) begin
      stub_act <= 1'b0;
      stub_rdy <= 1'b0;
      stub_k   <= 0;
      stub_res <= '0;
    end else if (stub_act) begin
      if (stub_k == 34) begin
        stub_act <= 1'b0;
        stub_rdy <= 1'b0;
      end else begin
        stub_k   <= stub_k + 1;
        stub_rdy <= (stub_k + 1 == 34);
      end
    end else if (core_start && !core_busy) begin
      stub_act <= 1'b1;
      stub_k   <= 1;
      stub_rdy <= 1'b0;
      stub_res <= core_encrypt ? ~core_data_in
                               : core_data_in ^ core_key[63:0];
    end
  end

  assign core_busy     = stub_act | force_busy;
  assign core_ready    = stub_rdy | spur;
  assign core_data_out = stub_res;

  // model: phase 0 idle, 1 start, 2 wait, 3 respond
  int           m_phase = 0;
  int           m_ptr = 0;
  int           m_gid = 0;
  logic [63:0]  m_data = '0;
  logic [255:0] m_key = '0;
  logic         m_enc = 1'b0;
  logic [63:0]  m_exp = '0;

  always @(negedge clk) begin
    int         pk;
    logic [3:0] e_rr;
    logic [3:0] e_rv;
    logic       e_cs;
    pk = -1;
    for (int i = 0; i < 4; i++)
      if (pk < 0 && req_valid[(m_ptr + i) % 4]) pk = (m_ptr + i) % 4;
    e_rr = '0;
    e_rv = '0;
    e_cs = 1'b0;
    if (m_phase == 0 && pk >= 0) e_rr[pk] = 1'b1;
    if (m_phase == 1) e_cs = !core_busy;
    if (m_phase == 3) e_rv[m_gid] = 1'b1;
    if (chk_en) begin
      chk("m_req_ready", req_ready, e_rr);
      chk("m_rsp_valid", rsp_valid, e_rv);
      chk("m_core_start", core_start, e_cs);
      chk("m_grant_id", grant_id, m_gid);
      chk("m_rsp_err", rsp_err, 0);
      if (m_phase == 3) chk("m_rsp_data", rsp_data, m_exp);
      if (m_phase == 1 || m_phase == 2) begin
        chk("m_core_data", core_data_in, m_data);
        chk("m_core_key", core_key, m_key);
        chk("m_core_enc", core_encrypt, m_enc);
      end
    end
    if (rst) begin
      m_phase = 0;
      m_ptr   = 0;
      m_gid   = 0;
    end else begin
      case (m_phase)
        0: if (pk >= 0) begin
          m_gid   = pk;
          m_data  = req_data[pk*64 +: 64];
          m_key   = req_key[pk*256 +: 256];
          m_enc   = req_encrypt[pk];
          m_exp   = m_enc ? ~m_data : m_data ^ m_key[63:0];
          m_phase = 1;
        end
        1: if (!core_busy) m_phase = 2;
        2: if (core_ready) m_phase = 3;
        default: if (rsp_ready[m_gid]) begin
          m_ptr   = (m_gid + 1) % 4;
          m_phase = 0;
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid  = '0;
    rsp_ready  = '1;
    force_busy = 1'b0;
    spur       = 1'b0;
    repeat (80) tick();
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, {req_ready, rsp_valid, grant_id, core_start,
                       core_encrypt, rsp_err}, 0);
    chk({nm, "_rsp_data"}, rsp_data, 0);
    chk({nm, "_core_data"}, core_data_in, 0);
    chk({nm, "_core_key"}, core_key, 0);
  endtask

  initial begin
    int g;
    int starts;
    bit got;
    int n;
    int order [5];
    int idx;
    rst = 1'b1;
    req_valid = '0;
    req_data = '0;
    req_key = '0;
    req_encrypt = '0;
    rsp_ready = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk_en = 1'b1;
    check_zero("reset");

    // single request on 2 plus backpressure
    req_data[2*64 +: 64] = 64'hFEDCBA9876543210;
    req_encrypt = 4'b0100;
    req_valid = 4'b0100;
    #1;
    chk("t1_grant", req_ready, 4'b0100);
    g = cyc;
    starts = 0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (i == 0) begin
        chk("t1_pulse", req_ready, 0);
        req_valid = '0;
      end
      starts += int'(core_start);
      if (rsp_valid != 0) got = 1;
    end
    chk("t1_seen", got, 1);
    chk("t1_latency", cyc - g, 36);
    chk("t1_starts", starts, 1);
    chk("t1_rsp_valid", rsp_valid, 4'b0100);
    chk("t1_rsp_data", rsp_data, 64'h0123456789ABCDEF);
    req_valid = 4'b1011;
    rsp_ready = 4'b1011;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_valid", rsp_valid, 4'b0100);
      chk("bp_data", rsp_data, 64'h0123456789ABCDEF);
      chk("bp_no_req", req_ready, 0);
    end
    rsp_ready = 4'b0100;
    tick();
    chk("bp_release", rsp_valid, 0);
    chk("bp_idle_grant", req_ready, 4'b1000);
    drain();

    // spurious core_ready while idle, then busy core at start
    rsp_ready = '0;
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("spur_idle", {req_ready, rsp_valid}, 0);
    end
    spur = 1'b0;
    force_busy = 1'b1;
    req_valid = 4'b0010;
    #1;
    chk("busy_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int i = 0; i < 5; i++) begin
      chk("busy_hold", core_start, 0);
      if (i < 4) tick();
    end
    tick();
    force_busy = 1'b0;
    #1;
    chk("busy_start", core_start, 1);
    tick();
    chk("busy_once", core_start, 0);
    drain();

    // fairness from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 4'b1111;
    #1;
    n = 0;
    for (int i = 0; i < 400 && n < 5; i++) begin
      if (req_ready != 0) begin
        idx = 0;
        for (int j = 0; j < 4; j++) if (req_ready[j]) idx = j;
        order[n] = idx;
        n++;
      end
      tick();
    end
    chk("fair_count", n, 5);
    chk("fair_0", order[0], 0);
    chk("fair_1", order[1], 1);
    chk("fair_2", order[2], 2);
    chk("fair_3", order[3], 3);
    chk("fair_4", order[4], 0);
    drain();

    // reset in the middle of WAIT
    req_valid = 4'b0100;
    #1;
    chk("rw_grant", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    repeat (11) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_zero("rw_after");
    req_valid = 4'b1001;
    #1;
    chk("rw_ptr0", req_ready, 4'b0001);
    drain();

    // random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 399) == 0);
      req_valid = 4'($urandom);
      req_encrypt = 4'($urandom);
      rsp_ready = 4'($urandom);
      for (int i = 0; i < 4; i++) req_data[i*64 +: 64] = {$urandom, $urandom};
      for (int i = 0; i < 32; i++) req_key[i*32 +: 32] = $urandom;
      force_busy = ($urandom_range(0, 7) == 0);
      spur = (m_phase == 0) && ($urandom_range(0, 7) == 0);
      tick();
    end
    rst = 1'b0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/magma_req_arbiter.md
Name: magma_req_arbiter

Overview:
- Shares one magma_cipher (ECB block) core among NUM_REQ independent requesters.
- Round-robin arbitration; accepts one request, latches its block, key and direction, then sequences the core's start/ready protocol.
- Returns the result to the granted requester through a valid/ready response with backpressure.
- Sits between client engines (CTR/MAC mode units) and the single shared cipher instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- BLOCK_SIZE, 64, block width in bits
- KEY_SIZE, 256, key width in bits
- TIMEOUT_CYCLES, 64, watchdog limit in cycles; used only with MAGMA_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  request accepted this cycle (one-hot or zero)
- req_data  in  NUM_REQ*BLOCK_SIZE  input blocks; requester i uses slice [i*BLOCK_SIZE +: BLOCK_SIZE]
- req_key  in  NUM_REQ*KEY_SIZE  keys, same slicing as req_data
- req_encrypt  in  NUM_REQ  1 = encrypt, 0 = decrypt
- rsp_valid  out  NUM_REQ  result available, one-hot to the owning requester
- rsp_ready  in  NUM_REQ  requester takes the result
- rsp_data  out  BLOCK_SIZE  result block, shared by all requesters
- rsp_err  out  1  result invalid (timeout); constant 0 without the macro
- grant_id  out  $clog2(NUM_REQ)  index of the current owner
- core_start  out  1  to core start
- core_encrypt  out  1  to core encrypt
- core_data_in  out  BLOCK_SIZE  to core data_in
- core_key  out  KEY_SIZE  to core key_in
- core_data_out  in  BLOCK_SIZE  from core data_out
- core_busy  in  1  from core busy
- core_ready  in  1  from core ready

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. The top level drives the core's rst_n from ~rst.
- Reset values:
  - All outputs are 0.
  - FSM goes to IDLE.
  - Round-robin pointer is 0, so requester 0 has highest priority first.
  - Latched data, key and encrypt registers are 0.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid is set, pick the first set bit scanning from the pointer upward, with wrap-around.
  - In the same cycle: req_ready[g] = 1 (combinational); latch req_data, req_key and req_encrypt of g; set grant_id <= g; go to START.
  - If no request is pending, stay in IDLE and req_ready = 0.
- START:
  - core_start = 1 only while core_busy = 0.
  - Go to WAIT after the first cycle in which core_start = 1 and core_busy = 0.
  - If core_busy = 1, stay in START with core_start = 0.
- WAIT:
  - core_start = 0.
  - On core_ready = 1: rsp_data <= core_data_out, go to RESP.
  - The present core asserts core_ready 34 cycles after the start cycle. The controller must not depend on that number.
- core_data_in, core_key and core_encrypt:
  - Driven from the latched registers continuously from START until leaving WAIT.
  - Stable for the whole operation, because the core reads the key every round.
- RESP:
  - rsp_valid[grant_id] = 1; rsp_data is held stable.
  - On rsp_ready[grant_id], go to IDLE and set pointer <= grant_id + 1 (mod NUM_REQ).
  - rsp_ready bits of non-owners are ignored.
- Rates and latency:
  - One operation in flight; no requests are accepted outside IDLE.
  - req_ready is never asserted in the same cycle as rsp_valid.
  - Latency from req_ready to rsp_valid: 1 (START) + core latency + 1.
- Boundary cases:
  - core_ready outside WAIT: ignored.
  - Requester drops req_valid before grant: allowed, nothing happens.
  - Owner re-asserts req_valid during RESP: it is arbitrated only after returning to IDLE, with lowest priority.
  - Reset mid-operation: the FSM aborts to IDLE, and any pending response is discarded.
  - Pointer wraps from NUM_REQ-1 to 0.

Optional Feature:
- Macro: MAGMA_ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without core_ready, go to RESP with rsp_data = 0 and rsp_err = 1.
  - rsp_err is held until the response handshake, then cleared.
  - The counter clears on entering WAIT.
- Not defined:
  - No counter is built and rsp_err is tied to 0.
  - WAIT waits indefinitely.

Test Plan:
- Single request: req_valid[2] = 1, data 64'hFEDCBA9876543210, encrypt = 1, with a core stub returning ~data after 34 cycles -> req_ready[2] pulses for 1 cycle; core_start pulses once; rsp_valid = 4'b0100 with rsp_data = 64'h0123456789ABCDEF 36 cycles after the grant.
- Fairness: req_valid = 4'b1111 held, rsp_ready tied to 1 -> grant order 0,1,2,3,0; no requester is granted twice before the others.
- Backpressure: rsp_ready[1] held at 0 for 10 cycles -> rsp_valid[1] and rsp_data stay stable; req_ready stays 0 even with other requests pending; IDLE is re-entered the cycle after rsp_ready[1] = 1.
- Core busy at start: core_busy = 1 for 5 cycles after the grant -> core_start stays 0 until core_busy falls, then pulses exactly once; spurious core_ready in IDLE is ignored.
- Reset mid-WAIT: rst = 1 for 1 cycle at WAIT cycle 10 -> all outputs 0 next cycle; pointer is 0; the next request from 0 is granted first.
- Timeout (macro defined, TIMEOUT_CYCLES = 64): core stub never asserts core_ready -> RESP is entered 64 cycles into WAIT with rsp_err = 1 and rsp_data = 0.
